host_req_queue: RTL and testbench
=================================

# host_req_queue

Per-host request queue and issue engine placed directly upstream of the crossbar, one instance per host port. It buffers up to DEPTH host commands (read/write, address, write data) and issues them one at a time on the crossbar's per-host req/cmd/addr/wdata lanes, holding each request until ack. After a read is acknowledged, it raises resp for one cycle and returns the captured read word to the host as a one-cycle valid pulse.

## Interface
- DW, 32, data width
- AW, 32, address width
- DEPTH, 4, queue entries; power of two, >= 2; CW = $clog2(DEPTH+1)

- clk_i  in  1  clock, all logic on rising edge
- reset_i  in  1  asynchronous reset, active-high; one clock; reset is asynchronous and active-high
- push_i  in  1  host enqueue strobe
- push_cmd_i  in  1  0 read, 1 write
- push_addr_i  in  AW  request address
- push_wdata_i  in  DW  write data (ignored for reads, still stored)
- full_o  out  1  count_o == DEPTH
- count_o  out  CW  occupied entries
- ovf_o  out  1  sticky: push attempted while full
- rd_valid_o  out  1  one-cycle pulse, rd_data_o valid
- rd_data_o  out  DW  returned read word, held until next read completes
- req_o  out  1  request to crossbar
- cmd_o  out  1  command of issued entry
- addr_o  out  AW  address of issued entry
- wdata_o  out  DW  write data of issued entry
- ack_i  in  1  crossbar request confirmation
- resp_o  out  1  read-data accept strobe to crossbar
- rdata_i  in  DW  crossbar read data
- busy_o  out  1  FSM not in IDLE or count_o != 0

## Operation
- Queue: circular buffer, write/read pointers log2(DEPTH) bits, wrap modulo DEPTH; count_o separate register.
- Push accepted iff push_i && count_o < DEPTH in that cycle; a same-cycle pop does not make room. Rejected push: entry dropped, ovf_o set, stays set until reset.
- FSM states IDLE, REQ, RESP.
  - IDLE: if count_o != 0 -> REQ; head entry registered into cmd_o/addr_o/wdata_o on that transition.
  - REQ: req_o = 1, fields stable. On ack_i: head popped (read pointer +1, count -1), then cmd_o == 1 -> IDLE, cmd_o == 0 -> RESP.
  - RESP: resp_o = 1 for exactly one cycle; rdata_i captured into rd_data_o at end of this cycle; rd_valid_o = 1 next cycle; -> IDLE.
- Simultaneous push and pop: count unchanged, both pointers advance.
- ack_i outside REQ: ignored. rdata_i outside RESP: ignored.
- All outputs registered. Reset values: req_o 0, cmd_o 0, addr_o 0, wdata_o 0, resp_o 0, rd_valid_o 0, rd_data_o 0, full_o 0, count_o 0, ovf_o 0, busy_o 0; pointers 0; FSM IDLE. Queue storage need not be reset.
- Reset mid-operation: outstanding request and all queued entries discarded; req_o/resp_o drop asynchronously.

## Timing
- Push at edge N -> count_o/full_o updated after N.
- Queue non-empty at edge N in IDLE -> req_o high from N+1.
- ack_i sampled high at edge M -> req_o low after M; count_o decremented after M.
- Write: FSM IDLE after M; next request earliest req_o at M+2 (one IDLE cycle between requests).
- Read: resp_o high during cycle after M; rd_valid_o high and rd_data_o valid the following cycle; next req_o earliest one cycle after that.
- ack_i held high indefinitely in REQ: each entry still costs one IDLE cycle; no double pop.
- Throughput: writes one per 2 cycles, reads one per 3 cycles.

## Test plan
- Reset then idle: all outputs 0, busy_o 0; pulse reset_i mid-REQ -> req_o 0 immediately, count_o 0.
- Push write addr 0x10 data 0xDEADBEEF, ack_i 3 cycles after req_o rises -> req_o/cmd_o=1/addr_o=0x10/wdata_o=0xDEADBEEF stable until ack, then req_o 0, count_o 0, no resp_o.
- Push read addr 0x20, ack, crossbar drives rdata_i 0xCAFEF00D in resp_o cycle -> single resp_o pulse, rd_valid_o pulse next cycle, rd_data_o 0xCAFEF00D held.
- DEPTH=4: push 5 writes with ack_i low -> count_o 4, full_o 1, ovf_o 1, 5th lost; then ack all -> exactly 4 issued, in push order.
- Push while full with ack in same cycle -> push rejected, count_o 3; next push accepted; pointers wrap past DEPTH with correct order over 10 mixed commands.
- ack_i tied high, 3 queued reads -> req_o pulses with 2 idle cycles between (resp + IDLE), 3 rd_valid_o pulses, count_o 0.

Source files
------------

// File: rtl/host_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : host_req_queue
// Description : Per-host command queue and single-outstanding issue engine
//               feeding one host lane of the crossbar. Buffers read/write
//               commands, presents the head entry until ack, and returns
//               read data to the host as a one-cycle valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module host_req_queue #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  // host enqueue side
  input  logic          push_i,
  input  logic          push_cmd_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [DW-1:0] push_wdata_i,
  output logic          full_o,
  output logic [CW-1:0] count_o,
  output logic          ovf_o,
  // host read return
  output logic          rd_valid_o,
  output logic [DW-1:0] rd_data_o,
  // crossbar lane
  output logic          req_o,
  output logic          cmd_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wdata_o,
  input  logic          ack_i,
  output logic          resp_o,
  input  logic [DW-1:0] rdata_i,
  // status
  output logic          busy_o
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic          cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  state_t        state;
  logic          push_ok;
  logic          pop;
  logic [CW-1:0] count_nxt;
  entry_t        head;

  assign head = mem[rd_ptr];

  // Push acceptance looks only at the current occupancy: a pop in the same
  // cycle does not free a slot for the incoming entry.
  always_comb begin
    push_ok   = push_i && (count_o != CW'(DEPTH));
    pop       = (state == REQ) && ack_i;
    count_nxt = count_o;
    if (push_ok && !pop) begin
      count_nxt = count_o + CW'(1);
    end else if (!push_ok && pop) begin
      count_nxt = count_o - CW'(1);
    end
  end

  // Queue storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= {push_cmd_i, push_addr_i, push_wdata_i};
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
      full_o  <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push_i && !push_ok) begin
        ovf_o <= 1'b1;
      end
      count_o <= count_nxt;
      full_o  <= (count_nxt == CW'(DEPTH));
    end
  end

  // Issue FSM: load head, hold request until ack, then one response cycle
  // for reads before returning the captured word to the host.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= IDLE;
      req_o      <= 1'b0;
      cmd_o      <= 1'b0;
      addr_o     <= '0;
      wdata_o    <= '0;
      resp_o     <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      busy_o     <= 1'b0;
    end else begin
      rd_valid_o <= 1'b0;
      busy_o     <= (count_nxt != '0);
      case (state)
        IDLE: begin
          if (count_o != '0) begin
            state   <= REQ;
            req_o   <= 1'b1;
            cmd_o   <= head.cmd;
            addr_o  <= head.addr;
            wdata_o <= head.wdata;
            busy_o  <= 1'b1;
          end
        end
        REQ: begin
          if (ack_i) begin
            req_o <= 1'b0;
            if (cmd_o) begin
              state <= IDLE;
            end else begin
              state  <= RESP;
              resp_o <= 1'b1;
              busy_o <= 1'b1;
            end
          end else begin
            busy_o <= 1'b1;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_o     <= 1'b0;
          rd_data_o  <= rdata_i;
          rd_valid_o <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          req_o  <= 1'b0;
          resp_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_host_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_host_req_queue
// Description : Self-checking bench for host_req_queue. A queue-based model
//               predicts every output after each clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_host_req_queue;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          push_i;
  logic          push_cmd_i;
  logic [AW-1:0] push_addr_i;
  logic [DW-1:0] push_wdata_i;
  logic          full_o;
  logic [CW-1:0] count_o;
  logic          ovf_o;
  logic          rd_valid_o;
  logic [DW-1:0] rd_data_o;
  logic          req_o;
  logic          cmd_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic          ack_i;
  logic          resp_o;
  logic [DW-1:0] rdata_i;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  host_req_queue #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .push_i(push_i), .push_cmd_i(push_cmd_i), .push_addr_i(push_addr_i),
    .push_wdata_i(push_wdata_i), .full_o(full_o), .count_o(count_o),
    .ovf_o(ovf_o), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .req_o(req_o), .cmd_o(cmd_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .ack_i(ack_i), .resp_o(resp_o), .rdata_i(rdata_i), .busy_o(busy_o)
  );

  typedef struct packed {
    logic          cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } ent_t;

  // Reference model: pending commands in order, the command on the lane,
  // and which phase of a transaction is visible on the outputs.
  ent_t          mq[$];
  ent_t          m_cur;
  bit            m_req, m_resp, m_valid, m_ovf;
  logic [DW-1:0] m_rd;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_cur = '0; m_req = 0; m_resp = 0; m_valid = 0; m_ovf = 0; m_rd = '0;
  endtask

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_edge();
    bit acc;
    bit do_pop;
    acc    = push_i && (mq.size() < DEPTH);
    do_pop = 0;
    if (push_i && !acc) m_ovf = 1;
    m_valid = 0;
    if (m_req) begin
      if (ack_i) begin
        do_pop = 1;
        m_req  = 0;
        m_resp = !m_cur.cmd;
      end
    end else if (m_resp) begin
      m_resp  = 0;
      m_valid = 1;
      m_rd    = rdata_i;
    end else if (mq.size() != 0) begin
      m_req = 1;
      m_cur = mq[0];
    end
    if (do_pop) void'(mq.pop_front());
    if (acc) mq.push_back({push_cmd_i, push_addr_i, push_wdata_i});
  endtask

  task automatic check_all();
    chk("req",      32'(req_o),      32'(m_req));
    chk("cmd",      32'(cmd_o),      32'(m_cur.cmd));
    chk("addr",     addr_o,          m_cur.addr);
    chk("wdata",    wdata_o,         m_cur.wdata);
    chk("resp",     32'(resp_o),     32'(m_resp));
    chk("rd_valid", 32'(rd_valid_o), 32'(m_valid));
    chk("rd_data",  rd_data_o,       m_rd);
    chk("count",    32'(count_o),    32'(mq.size()));
    chk("full",     32'(full_o),     32'(mq.size() == DEPTH));
    chk("ovf",      32'(ovf_o),      32'(m_ovf));
    chk("busy",     32'(busy_o),     32'(m_req || m_resp || (mq.size() != 0)));
  endtask

  task automatic step(input bit p, input bit c, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input bit ack, input logic [DW-1:0] rd);
    push_i = p; push_cmd_i = c; push_addr_i = a; push_wdata_i = d;
    ack_i = ack; rdata_i = rd;
    @(posedge clk_i);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_step(input bit ack);
    step(1'b0, 1'b0, '0, '0, ack, $urandom);
  endtask

  task automatic do_reset();
    push_i = 0; push_cmd_i = 0; push_addr_i = '0; push_wdata_i = '0;
    ack_i = 0; rdata_i = '0;
    reset_i = 1;
    #1;
    model_clear();
    check_all();
    @(posedge clk_i);
    #1;
    reset_i = 0;
  endtask

  initial begin
    int pulses;
    reset_i = 0;
    do_reset();
    repeat (3) idle_step(1'b0);

    // Reset while a request is outstanding: req_o drops without a clock edge.
    step(1'b1, 1'b1, 32'h44, 32'h1234, 1'b0, '0);
    idle_step(1'b0);
    chk("req_before_reset", 32'(req_o), 32'd1);
    #2;
    reset_i = 1;
    #1;
    chk("req_async_reset", 32'(req_o), 32'd0);
    chk("count_async_reset", 32'(count_o), 32'd0);
    model_clear();
    @(posedge clk_i);
    #1;
    reset_i = 0;
    check_all();

    // Single write, ack three cycles after req_o rises.
    step(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, '0);
    idle_step(1'b0);
    chk("wr_req", 32'(req_o), 32'd1);
    chk("wr_addr", addr_o, 32'h10);
    chk("wr_data", wdata_o, 32'hDEADBEEF);
    idle_step(1'b0);
    idle_step(1'b0);
    idle_step(1'b1);
    chk("wr_req_after_ack", 32'(req_o), 32'd0);
    chk("wr_count_after_ack", 32'(count_o), 32'd0);
    idle_step(1'b0);
    chk("wr_no_resp", 32'(resp_o), 32'd0);

    // Single read returning 0xCAFEF00D.
    step(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, '0);
    idle_step(1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, '0);
    chk("rd_resp", 32'(resp_o), 32'd1);
    step(1'b0, 1'b0, '0, '0, 1'b0, 32'hCAFEF00D);
    chk("rd_valid", 32'(rd_valid_o), 32'd1);
    chk("rd_data", rd_data_o, 32'hCAFEF00D);
    idle_step(1'b0);
    chk("rd_data_held", rd_data_o, 32'hCAFEF00D);

    // Five writes with no ack: four stored, fifth lost, then drain in order.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'h100 + 32'(i), $urandom, 1'b0, '0);
    chk("fill_count", 32'(count_o), 32'd4);
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_ovf", 32'(ovf_o), 32'd1);
    repeat (10) idle_step(1'b1);
    chk("drain_count", 32'(count_o), 32'd0);

    // Push while full with a same-cycle ack: push rejected, then accepted.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h200 + 32'(i), $urandom, 1'b0, '0);
    step(1'b1, 1'b1, 32'h2FF, 32'h55, 1'b1, '0);
    chk("full_ack_count", 32'(count_o), 32'd3);
    chk("full_ack_ovf", 32'(ovf_o), 32'd1);
    step(1'b1, 1'b0, 32'h300, 32'h66, 1'b0, '0);
    chk("after_full_count", 32'(count_o), 32'd4);
    for (int i = 0; i < 10; i++) step(1'b1, 1'($urandom), $urandom, $urandom, 1'($urandom), $urandom);
    repeat (30) idle_step(1'b1);

    // ack_i tied high with three queued reads.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h400 + 32'(i), '0, 1'b1, $urandom);
      if (rd_valid_o) pulses++;
    end
    repeat (12) begin
      idle_step(1'b1);
      if (rd_valid_o) pulses++;
    end
    chk("ackhigh_pulses", 32'(pulses), 32'd3);
    chk("ackhigh_count", 32'(count_o), 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 2) != 0), 1'($urandom), $urandom, $urandom,
           1'($urandom_range(0, 2) != 0), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
